// File: rtl/ifetch_resp_pkg.sv
// Shared core header for the fetch path: address/data widths and the
// core-wide default fetch queue depth.
package ifetch_resp_pkg;

  // Width of a fetch address (PC_RANGE is [PC_W-1:0]).
  localparam int PC_W = 32;

  // Width of an instruction word (DATA_RANGE is [DATA_W-1:0]).
  localparam int DATA_W = 32;

  // Default number of queue entries / maximum outstanding fetches.
  localparam int IFQ_DEPTH = 4;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ifetch_queue.sv
// Fetch return queue: a ring of {pc, data, filled} entries with separate
// allocate, fill and read pointers. Each pointer carries an extra wrap bit
// so a completely full ring is distinguishable from an empty one.
module ifetch_queue
  import ifetch_resp_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic                     fill_en,
  input  logic [DATA_W-1:0]        fill_data,
  input  logic                     pop_en,
  output logic [$clog2(DEPTH):0]   used,
  output logic [$clog2(DEPTH):0]   in_flight,
  output logic                     head_valid,
  output logic [PC_W-1:0]          head_pc,
  output logic [DATA_W-1:0]        head_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  alloc_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [PTR_W-1:0]  read_ptr;
  logic [IDX_W-1:0]  alloc_idx;
  logic [IDX_W-1:0]  fill_idx;
  logic [IDX_W-1:0]  read_idx;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic [DEPTH-1:0]  fill_mask;
  logic [DEPTH-1:0]  pop_mask;

  assign alloc_idx = alloc_ptr[IDX_W-1:0];
  assign fill_idx  = fill_ptr[IDX_W-1:0];
  assign read_idx  = read_ptr[IDX_W-1:0];

  // Entries between read and alloc are owned (buffered or awaiting data);
  // entries between fill and alloc are still waiting on memory.
  assign used      = alloc_ptr - read_ptr;
  assign in_flight = alloc_ptr - fill_ptr;

  assign head_valid = filled[read_idx];
  assign head_pc    = pc_mem[read_idx];
  assign head_data  = data_mem[read_idx];

  // One-hot masks for the entry being filled and the entry being popped.
  always_comb begin
    fill_mask = '0;
    pop_mask  = '0;
    if (fill_en) begin
      fill_mask[fill_idx] = 1'b1;
    end
    if (pop_en) begin
      pop_mask[read_idx] = 1'b1;
    end
  end

  // Pointer and filled-bit update; a flush collapses every pointer onto the
  // allocation point so all older entries vanish at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      filled    <= '0;
    end else if (flush) begin
      fill_ptr  <= alloc_ptr;
      read_ptr  <= alloc_ptr;
      filled    <= '0;
    end else begin
      if (alloc_en) begin
        alloc_ptr <= alloc_ptr + PTR_W'(1);
      end
      if (fill_en) begin
        fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        read_ptr <= read_ptr + PTR_W'(1);
      end
      filled <= (filled & ~pop_mask) | fill_mask;
    end
  end

  // Entry payload storage: pc is captured at issue, data at response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (!flush) begin
      if (alloc_en) begin
        pc_mem[alloc_idx] <= alloc_pc;
      end
      if (fill_en) begin
        data_mem[fill_idx] <= fill_data;
      end
    end
  end

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: issues PCs to a pipelined in-order
// instruction memory under a credit limit, buffers the returned words and
// hands {pc, instruction} pairs to decode. A redirect discards everything
// older and remembers how many stale responses are still owed by memory.
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pc_valid,
  input  logic [PC_W-1:0]   pc_in,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [PC_W-1:0]   inst_pc,
  output logic [DATA_W-1:0] inst_data,
  input  logic              inst_ready
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] used;
  logic [PTR_W-1:0] in_flight;
  logic [PTR_W-1:0] drop_cnt;
  logic [PTR_W:0]   committed;
  logic             credit;
  logic             drop_resp;
  logic             fill_en;
  logic             pop_en;

  // Issue, drop and pop decisions. Credit counts both live entries and
  // responses still owed for killed fetches, so the ring can never overflow.
  always_comb begin
    committed = {1'b0, used} + {1'b0, drop_cnt};
    credit    = committed < (PTR_W + 1)'(DEPTH);
    imem_req  = pc_valid & credit & ~flush & ~rst;
    pc_ready  = imem_req & imem_gnt;
    drop_resp = imem_rvalid & (drop_cnt != '0);
    fill_en   = imem_rvalid & ~drop_resp & ~flush;
    pop_en    = inst_valid & inst_ready & ~flush;
  end

  assign imem_addr = pc_in;

  // Owed-response counter: on a redirect every fetch still in memory becomes
  // owed, minus the response landing this very cycle, which is dropped now.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_cnt + in_flight - PTR_W'(imem_rvalid);
    end else if (drop_resp) begin
      drop_cnt <= drop_cnt - PTR_W'(1);
    end
  end

  ifetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_en   (pc_ready),
    .alloc_pc   (pc_in),
    .fill_en    (fill_en),
    .fill_data  (imem_rdata),
    .pop_en     (pop_en),
    .used       (used),
    .in_flight  (in_flight),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_data  (inst_data)
  );

endmodule

// File: tb/tb_ifetch_resp.sv
// Self-checking bench for ifetch_resp: an in-order memory model with
// variable latency, a slot-counting credit model and a scoreboard of
// accepted fetches that a separate monitor checks against decode output.
module tb_ifetch_resp;
  import ifetch_resp_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          killed;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    int          dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  int  cycle = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  grants = 0;
  int  last_due = 0;
  int  kmin = 1;
  int  kmax = 1;
  int  ready_mode = 1;
  bit  gnt_rand = 0;
  bit  ready_pulse = 0;
  bit  rst_req = 1;
  bit  flush_req = 0;
  bit  exp_req = 0;

  logic [31:0] src_q[$];
  mem_t        mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] pop_pcs[$];
  int          pop_cycles[$];
  int          grant_cycles[$];

  ifetch_resp #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .pc_valid    (pc_valid),
    .pc_in       (pc_in),
    .pc_ready    (pc_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .inst_data   (inst_data),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  // Contents of instruction memory at a given address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // One clock cycle: drive inputs after the edge, sample at the falling edge.
  task automatic applyStimulus();
    int slots;
    int k;
    int due;
    @(posedge clk);
    cycle++;
    #1;
    rst   = rst_req;
    flush = flush_req;
    flush_req = 0;
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      last_due = 0;
    end
    slots = exp_q.size();
    foreach (mem_q[i]) if (mem_q[i].killed) slots++;
    pc_valid = (src_q.size() > 0);
    pc_in    = pc_valid ? src_q[0] : ($urandom & 32'hFFFF_FFFC);
    exp_req  = !rst && !flush && pc_valid && (slots < DEPTH);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      if (!mem_q[0].killed) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].dcyc < 0) begin
            exp_q[i].dcyc = cycle;
            break;
          end
        end
      end
      void'(mem_q.pop_front());
    end
    imem_gnt   = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    inst_ready = (ready_mode == 2) ? 1'($urandom_range(1, 0))
               : ((ready_mode == 1) || ready_pulse);
    ready_pulse = 0;
    @(negedge clk);
    checkOutput("imem_req", imem_req, exp_req);
    checkOutput("pc_ready", pc_ready, exp_req & imem_gnt);
    if (!rst && pc_ready) begin
      checkOutput("imem_addr", imem_addr, pc_in);
      k   = $urandom_range(kmax, kmin);
      due = cycle + k;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{pc: pc_in, data: memWord(pc_in), due: due, killed: 0});
      exp_q.push_back('{pc: pc_in, dcyc: -1});
      grants++;
      grant_cycles.push_back(cycle);
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (!rst && flush) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].killed = 1;
    end
  endtask

  task automatic startTest();
    pop_pcs.delete();
    pop_cycles.delete();
    grant_cycles.delete();
  endtask

  task automatic runUntilDrained(input string name, input int limit);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || mem_q.size() > 0) && n < limit) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, 32'(src_q.size() + exp_q.size() + mem_q.size()), 32'd0);
  endtask

  // Monitor: whenever decode takes an entry, it must be the oldest live fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !flush) begin
        if (exp_q.size() > 0 && exp_q[0].dcyc >= 0 && cycle > exp_q[0].dcyc)
          checkOutput("inst_valid_on_time", inst_valid, 1);
        if (inst_valid && inst_ready) begin
          checkOutput("pop_has_model_entry", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("inst_pc", inst_pc, e.pc);
            checkOutput("inst_data", inst_data, memWord(e.pc));
            checkOutput("entry_returned_before_valid",
                        32'(e.dcyc >= 0 && cycle > e.dcyc), 32'd1);
            pop_pcs.push_back(inst_pc);
            pop_cycles.push_back(cycle);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g0;
    logic [31:0] rand_pcs[$];
    rst = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc_in = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

    // Reset and idle state
    rst_req = 1;
    repeat (2) applyStimulus();
    rst_req = 0;
    applyStimulus();
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_inst_data", inst_data, 0);

    // Streaming, k=1, decode always ready
    $display("[TB] streaming");
    startTest();
    src_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    runUntilDrained("stream_drain", 40);
    checkOutput("stream_pops", pop_pcs.size(), 4);
    if (pop_cycles.size() == 4 && grant_cycles.size() > 0) begin
      checkOutput("stream_first_latency", 32'(pop_cycles[0] - grant_cycles[0]), 2);
      checkOutput("stream_back_to_back", 32'(pop_cycles[3] - pop_cycles[0]), 3);
    end

    // Backpressure: decode stalled
    $display("[TB] backpressure");
    startTest();
    ready_mode = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(32'h200 + 32'(4 * i));
    g0 = grants;
    repeat (10) applyStimulus();
    checkOutput("bp_grants", 32'(grants - g0), DEPTH);
    checkOutput("bp_req_low", imem_req, 0);
    ready_pulse = 1;
    applyStimulus();
    repeat (6) applyStimulus();
    checkOutput("bp_one_more_grant", 32'(grants - g0), DEPTH + 1);
    ready_mode = 1;
    runUntilDrained("bp_drain", 60);
    checkOutput("bp_pops", pop_pcs.size(), 8);

    // Flush with three fetches in flight
    $display("[TB] flush with fetches in flight");
    startTest();
    kmin = 5; kmax = 5;
    src_q = '{32'h300, 32'h304, 32'h308};
    repeat (3) applyStimulus();
    flush_req = 1;
    applyStimulus();
    src_q.push_back(32'h100);
    runUntilDrained("flush3_drain", 60);
    checkOutput("flush3_pops", pop_pcs.size(), 1);
    if (pop_pcs.size() > 0) checkOutput("flush3_first_pc", pop_pcs[0], 32'h100);

    // Flush in the same cycle as a response
    $display("[TB] flush coinciding with response");
    startTest();
    kmin = 2; kmax = 2;
    src_q = '{32'h400, 32'h404};
    repeat (2) applyStimulus();
    flush_req = 1;
    applyStimulus();
    src_q.push_back(32'h500);
    runUntilDrained("flushrv_drain", 40);
    checkOutput("flushrv_pops", pop_pcs.size(), 1);
    if (pop_pcs.size() > 0) checkOutput("flushrv_first_pc", pop_pcs[0], 32'h500);

    // Random grant stalls, latency 1..3, random decode readiness
    $display("[TB] random grant stalls");
    startTest();
    gnt_rand = 1; kmin = 1; kmax = 3; ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rand_pcs.push_back($urandom & 32'hFFFF_FFFC);
      src_q.push_back(rand_pcs[i]);
    end
    g0 = grants;
    runUntilDrained("rand_drain", 2000);
    checkOutput("rand_grants", 32'(grants - g0), 40);
    checkOutput("rand_pops", pop_pcs.size(), 40);
    for (int i = 0; i < 40 && i < pop_pcs.size(); i++)
      checkOutput("rand_order", pop_pcs[i], rand_pcs[i]);

    // Reset while two entries are buffered
    $display("[TB] reset with buffered entries");
    startTest();
    gnt_rand = 0; kmin = 1; kmax = 1; ready_mode = 0;
    src_q = '{32'h600, 32'h604};
    repeat (4) applyStimulus();
    checkOutput("prerst_inst_valid", inst_valid, 1);
    rst_req = 1;
    applyStimulus();
    rst_req = 0;
    applyStimulus();
    checkOutput("postrst_inst_valid", inst_valid, 0);
    for (int i = 0; i < 6; i++) src_q.push_back(32'h700 + 32'(4 * i));
    g0 = grants;
    repeat (8) applyStimulus();
    checkOutput("postrst_credit", 32'(grants - g0), DEPTH);
    ready_mode = 1;
    runUntilDrained("postrst_drain", 60);
    checkOutput("postrst_pops", pop_pcs.size(), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
